// File: rtl/dm_pkg.sv
// ============================================================================
// Module   : dm_pkg
// Desc     : Shared widths, entry layout and fence states for the store buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package dm_pkg;
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int WORD_LSB = 2;

    typedef struct packed {
        logic [ADDR_W-1:WORD_LSB] addr;
        logic [DATA_W-1:0]        data;
    } sb_entry_t;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        FENCE  = 2'd1,
        DONE   = 2'd2
    } sb_state_e;
endpackage

`default_nettype wire

// File: rtl/sb_fwd_match.sv
// ============================================================================
// Module   : sb_fwd_match
// Desc     : Youngest-first word-address match over the buffered stores.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sb_fwd_match
    import dm_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  sb_entry_t                i_entries [DEPTH],
    input  logic [DEPTH-1:0]         i_valid,
    input  logic [PTR_W-1:0]         i_wr_ptr,
    input  logic [ADDR_W-1:WORD_LSB] i_ld_word,
    output logic                     o_hit,
    output logic [DATA_W-1:0]        o_data
);

    logic [PTR_W-1:0] w_idx;

    // Walk oldest to youngest so the last match written is the youngest one.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        w_idx  = '0;
        for (int i = DEPTH; i >= 1; i--) begin
            w_idx = i_wr_ptr - PTR_W'(i);
            if (i_valid[w_idx] && (i_entries[w_idx].addr == i_ld_word)) begin
                o_hit  = 1'b1;
                o_data = i_entries[w_idx].data;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/store_buffer.sv
// ============================================================================
// Module   : store_buffer
// Desc     : Posted-write store FIFO with load forwarding and fence drain.
//            Macro STORE_MERGE_EN folds same-word stores into the youngest entry.
// Revision : 1.0
// ============================================================================
`default_nettype none

module store_buffer
    import dm_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     st_valid,
    input  logic [ADDR_W-1:0]        st_addr,
    input  logic [DATA_W-1:0]        st_data,
    output logic                     st_ready,
    input  logic                     ld_valid,
    input  logic [ADDR_W-1:0]        ld_addr,
    output logic                     fwd_hit,
    output logic [DATA_W-1:0]        fwd_data,
    input  logic                     dm_hold,
    output logic                     dm_MemWr,
    output logic [ADDR_W-1:0]        dm_addr,
    output logic [DATA_W-1:0]        dm_data,
    input  logic                     fence_req,
    output logic                     fence_done,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] c_DEPTH_CNT = (PTR_W+1)'(DEPTH);

    sb_entry_t        entries_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    sb_state_e        state_q;
    logic             fence_done_q;

    logic             w_push;
    logic             w_pop;
    logic             w_merge;
    logic             w_alloc;
    logic [DEPTH-1:0] w_valid;
    logic             w_fwd_hit;
    logic [DATA_W-1:0] w_fwd_data;
    logic             w_unused;

    assign w_unused = ^{st_addr[WORD_LSB-1:0], ld_addr[WORD_LSB-1:0]};

    assign st_ready = (state_q == NORMAL) && (count_q < c_DEPTH_CNT);
    assign w_push   = st_valid && st_ready;
    assign w_pop    = (count_q != '0) && !dm_hold;

`ifdef STORE_MERGE_EN
    logic [PTR_W-1:0] w_tail;
    assign w_tail = wr_ptr_q - PTR_W'(1);

    // A lone entry that is leaving this cycle cannot absorb the new store.
    always_comb begin
        w_merge = w_push
               && (entries_q[w_tail].addr == st_addr[ADDR_W-1:WORD_LSB])
               && ((count_q >= (PTR_W+1)'(2))
                   || ((count_q == (PTR_W+1)'(1)) && !w_pop));
    end
`else
    always_comb begin
        w_merge = 1'b0;
    end
`endif

    assign w_alloc = w_push && !w_merge;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_alloc) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({w_alloc, w_pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_alloc) begin
            entries_q[wr_ptr_q].addr <= st_addr[ADDR_W-1:WORD_LSB];
            entries_q[wr_ptr_q].data <= st_data;
        end
`ifdef STORE_MERGE_EN
        else if (w_merge) begin
            entries_q[w_tail].data <= st_data;
        end
`endif
    end

    // FENCE exits on the emptiness that results after this cycle's pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= NORMAL;
            fence_done_q <= 1'b0;
        end else begin
            fence_done_q <= 1'b0;
            case (state_q)
                NORMAL: begin
                    if (fence_req) begin
                        state_q <= FENCE;
                    end
                end
                FENCE: begin
                    if (count_d == '0) begin
                        state_q      <= DONE;
                        fence_done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= fence_req ? FENCE : NORMAL;
                end
                default: begin
                    state_q <= NORMAL;
                end
            endcase
        end
    end

    for (genvar j = 0; j < DEPTH; j++) begin : g_valid
        logic [PTR_W-1:0] w_off;
        assign w_off      = PTR_W'(j) - rd_ptr_q;
        assign w_valid[j] = ({1'b0, w_off} < count_q);
    end

    sb_fwd_match #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fwd_match (
        .i_entries (entries_q),
        .i_valid   (w_valid),
        .i_wr_ptr  (wr_ptr_q),
        .i_ld_word (ld_addr[ADDR_W-1:WORD_LSB]),
        .o_hit     (w_fwd_hit),
        .o_data    (w_fwd_data)
    );

    assign fwd_hit    = ld_valid && w_fwd_hit;
    assign fwd_data   = w_fwd_data;
    assign dm_MemWr   = w_pop;
    assign dm_addr    = {entries_q[rd_ptr_q].addr, {WORD_LSB{1'b0}}};
    assign dm_data    = entries_q[rd_ptr_q].data;
    assign fence_done = fence_done_q;
    assign count      = count_q;

endmodule

`default_nettype wire

// File: tb/tb_store_buffer.sv
// ============================================================================
// Module   : tb_store_buffer
// Desc     : Directed self-checking bench for store_buffer (DEPTH=4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_store_buffer;

    logic        clk;
    logic        reset;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic        dm_hold;
    logic        dm_MemWr;
    logic [31:0] dm_addr;
    logic [31:0] dm_data;
    logic        fence_req;
    logic        fence_done;
    logic [2:0]  count;

    int          vectors     = 0;
    int          miscompares = 0;
    int          n_exp;
    logic [31:0] exp_a [3];
    logic [31:0] exp_d [3];

    store_buffer #(
        .DEPTH  (4),
        .ADDR_W (32),
        .DATA_W (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .st_valid   (st_valid),
        .st_addr    (st_addr),
        .st_data    (st_data),
        .st_ready   (st_ready),
        .ld_valid   (ld_valid),
        .ld_addr    (ld_addr),
        .fwd_hit    (fwd_hit),
        .fwd_data   (fwd_data),
        .dm_hold    (dm_hold),
        .dm_MemWr   (dm_MemWr),
        .dm_addr    (dm_addr),
        .dm_data    (dm_data),
        .fence_req  (fence_req),
        .fence_done (fence_done),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        #1;
        chk("push_ready", 32'(st_ready), 32'd1);
        tick();
        st_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0;
        ld_valid = 1'b0; ld_addr = '0; dm_hold = 1'b0; fence_req = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_ready", 32'(st_ready), 32'd1);
        chk("reset_memwr", 32'(dm_MemWr), 32'd0);
        chk("reset_fence_done", 32'(fence_done), 32'd0);

        // single store drains one cycle after acceptance
        push(32'h08, 32'hAA);
        #1;
        chk("st1_memwr", 32'(dm_MemWr), 32'd1);
        chk("st1_addr", dm_addr, 32'h08);
        chk("st1_data", dm_data, 32'hAA);
        chk("st1_count", 32'(count), 32'd1);
        tick();
        #1;
        chk("st1_count_after", 32'(count), 32'd0);
        chk("st1_memwr_after", 32'(dm_MemWr), 32'd0);

        // fill while held, then drain in order
        dm_hold = 1'b1;
        for (int i = 0; i < 4; i++) push(32'(i * 4), 32'h100 + 32'(i));
        st_valid = 1'b1; st_addr = 32'h30; st_data = 32'h55;
        #1;
        chk("full_count", 32'(count), 32'd4);
        chk("full_ready", 32'(st_ready), 32'd0);
        chk("full_memwr_held", 32'(dm_MemWr), 32'd0);
        st_valid = 1'b0;
        dm_hold  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("drain_memwr", 32'(dm_MemWr), 32'd1);
            chk("drain_addr", dm_addr, 32'(i * 4));
            chk("drain_data", dm_data, 32'h100 + 32'(i));
            if (i == 0) chk("drain_ready_full", 32'(st_ready), 32'd0);
            if (i == 1) chk("drain_ready_after_pop", 32'(st_ready), 32'd1);
            tick();
        end
        #1;
        chk("drain_empty_count", 32'(count), 32'd0);
        chk("drain_empty_memwr", 32'(dm_MemWr), 32'd0);

        // forwarding: same-cycle push is invisible, youngest wins afterwards
        dm_hold = 1'b1;
        push(32'h10, 32'd1);
        st_valid = 1'b1; st_addr = 32'h10; st_data = 32'd2;
        ld_valid = 1'b1; ld_addr = 32'h11;
        #1;
        chk("fwd_same_cycle_hit", 32'(fwd_hit), 32'd1);
        chk("fwd_same_cycle_data", fwd_data, 32'd1);
        tick();
        st_valid = 1'b0;
        #1;
        chk("fwd_young_hit", 32'(fwd_hit), 32'd1);
        chk("fwd_young_data", fwd_data, 32'd2);
        ld_addr = 32'h14;
        #1;
        chk("fwd_miss", 32'(fwd_hit), 32'd0);
        ld_addr = 32'h10; ld_valid = 1'b0;
        #1;
        chk("fwd_no_valid", 32'(fwd_hit), 32'd0);
        ld_valid = 1'b1; dm_hold = 1'b0;
        #1;
        chk("fwd_drain_memwr", 32'(dm_MemWr), 32'd1);
        chk("fwd_drain_hit", 32'(fwd_hit), 32'd1);
        chk("fwd_drain_data", fwd_data, 32'd2);
        tick();
        tick();
        #1;
        chk("fwd_empty_count", 32'(count), 32'd0);
        chk("fwd_empty_hit", 32'(fwd_hit), 32'd0);
        ld_valid = 1'b0;

        // fence with three entries buffered
        dm_hold = 1'b1;
        for (int i = 0; i < 3; i++) push(32'h40 + 32'(i * 4), 32'h200 + 32'(i));
        dm_hold = 1'b0; fence_req = 1'b1;
        #1;
        chk("fence0_memwr", 32'(dm_MemWr), 32'd1);
        chk("fence0_addr", dm_addr, 32'h40);
        tick();
        st_valid = 1'b1; st_addr = 32'h60; st_data = 32'hEE;
        for (int i = 1; i < 3; i++) begin
            #1;
            chk("fence_ready", 32'(st_ready), 32'd0);
            chk("fence_memwr", 32'(dm_MemWr), 32'd1);
            chk("fence_addr", dm_addr, 32'h40 + 32'(i * 4));
            chk("fence_data", dm_data, 32'h200 + 32'(i));
            chk("fence_done_low", 32'(fence_done), 32'd0);
            tick();
        end
        #1;
        chk("fence_done_pulse", 32'(fence_done), 32'd1);
        chk("fence_done_ready", 32'(st_ready), 32'd0);
        chk("fence_done_count", 32'(count), 32'd0);
        chk("fence_done_memwr", 32'(dm_MemWr), 32'd0);
        fence_req = 1'b0; st_valid = 1'b0;
        tick();
        #1;
        chk("fence_done_cleared", 32'(fence_done), 32'd0);
        chk("fence_normal_ready", 32'(st_ready), 32'd1);

        // fence on an already empty buffer: pulse two cycles after request
        fence_req = 1'b1;
        #1;
        chk("efence_req_cycle", 32'(fence_done), 32'd0);
        tick();
        fence_req = 1'b0;
        #1;
        chk("efence_ready", 32'(st_ready), 32'd0);
        chk("efence_not_yet", 32'(fence_done), 32'd0);
        tick();
        #1;
        chk("efence_pulse", 32'(fence_done), 32'd1);
        tick();
        #1;
        chk("efence_cleared", 32'(fence_done), 32'd0);
        chk("efence_ready_back", 32'(st_ready), 32'd1);

        // reset while draining drops pending stores
        dm_hold = 1'b1;
        push(32'h50, 32'h300);
        push(32'h54, 32'h301);
        dm_hold = 1'b0;
        #1;
        chk("rst_mid_memwr_before", 32'(dm_MemWr), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0; ld_valid = 1'b1; ld_addr = 32'h54;
        #1;
        chk("rst_mid_count", 32'(count), 32'd0);
        chk("rst_mid_memwr", 32'(dm_MemWr), 32'd0);
        chk("rst_mid_fwd", 32'(fwd_hit), 32'd0);
        ld_valid = 1'b0;
        tick();

        // same-word stores back to back
`ifdef STORE_MERGE_EN
        n_exp = 2;
        exp_a = '{32'h20, 32'h24, 32'h0};
        exp_d = '{32'd5, 32'd7, 32'd0};
`else
        n_exp = 3;
        exp_a = '{32'h20, 32'h24, 32'h24};
        exp_d = '{32'd5, 32'd6, 32'd7};
`endif
        dm_hold = 1'b1;
        push(32'h20, 32'd5);
        push(32'h24, 32'd6);
        push(32'h24, 32'd7);
        #1;
        chk("merge_count", 32'(count), 32'(n_exp));
        dm_hold = 1'b0;
        for (int i = 0; i < n_exp; i++) begin
            #1;
            chk("merge_memwr", 32'(dm_MemWr), 32'd1);
            chk("merge_addr", dm_addr, exp_a[i]);
            chk("merge_data", dm_data, exp_d[i]);
            tick();
        end
        #1;
        chk("merge_empty", 32'(count), 32'd0);
        chk("merge_memwr_idle", 32'(dm_MemWr), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write FIFO between the EX/MEM pipeline register and the data memory write port.
- Accepts stores in one cycle, then drains them to the data memory one entry per cycle, in order.
- Forwards the youngest matching buffered data to same-cycle loads.
- Supports a fence (drain-all) handshake for ordering-sensitive instructions.

Parameters:
DEPTH, 4, number of buffered stores; power of two, at least 2
ADDR_W, 32, byte address width
DATA_W, 32, store data width

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-high
st_valid  in  1  store request from EX/MEM
st_addr  in  ADDR_W  store byte address; bits [1:0] ignored
st_data  in  DATA_W  store data
st_ready  out  1  store accepted this cycle when st_valid is also high
ld_valid  in  1  load in MEM stage
ld_addr  in  ADDR_W  load byte address
fwd_hit  out  1  a buffered store matches ld_addr
fwd_data  out  DATA_W  data of the youngest matching entry
dm_hold  in  1  data memory write port unavailable this cycle
dm_MemWr  out  1  write strobe to the data memory
dm_addr  out  ADDR_W  head entry address
dm_data  out  DATA_W  head entry data
fence_req  in  1  level request: drain everything
fence_done  out  1  one-cycle pulse once the buffer is empty after a fence
count  out  log2(DEPTH)+1  occupancy

Behaviour:
- Storage: DEPTH entries {addr[ADDR_W-1:2], data}, plus wr_ptr, rd_ptr and count.
- Reset values (sync, on the posedge where reset=1): count=0, pointers=0, state=NORMAL, fence_done=0. Entry contents are don't-care. Pending stores are discarded; a reset mid-drain drops them.
- Push: st_ready = (state==NORMAL) && (count<DEPTH). No push-while-full even if a pop occurs in the same cycle.
- Push timing: an accepted store is written at the posedge. It is visible to drain and forwarding from the next cycle.
- Drain: dm_MemWr = (count!=0) && !dm_hold; combinational from the head entry.
  - dm_addr = {head.addr, 2'b00}; dm_data = head.data.
  - The data memory captures on the following negedge. The head pops on the posedge that ends a cycle with dm_MemWr=1.
  - Drain throughput is 1 store/cycle; minimum latency from store acceptance to strobe is 1 cycle.
  - When count==0: dm_MemWr=0 and dm_addr/dm_data are don't-care.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Pointer wrap: modulo DEPTH.
- Forwarding is combinational. Compare ld_addr[ADDR_W-1:2] against every valid entry; priority goes to the youngest (closest to wr_ptr-1).
  - fwd_hit=0 when ld_valid=0 or count==0; fwd_data is don't-care when fwd_hit=0.
  - The head being drained in the current cycle still forwards.
  - A store being pushed in the same cycle does not forward; the pipeline orders the store before the load.
- FSM:
  - NORMAL -> FENCE when fence_req=1.
  - FENCE: st_ready=0, drain continues.
  - FENCE -> DONE when count==0, evaluated after the pop of the current cycle.
  - DONE: fence_done=1 for exactly one cycle, then -> NORMAL.
  - fence_req with count==0 already: NORMAL -> FENCE -> DONE, so fence_done rises 2 cycles after the request.
  - fence_req held high across DONE re-enters FENCE and produces another pulse on the next empty.

Optional Feature:
STORE_MERGE_EN
- Defined:
  - An accepted store whose word address equals the youngest entry (wr_ptr-1) overwrites that entry's data; wr_ptr and count are unchanged.
  - Merge applies only when count>=2, or count==1 and that entry is not popping this cycle. Otherwise the store allocates normally.
  - st_ready is still computed from count<DEPTH, so a full buffer blocks even mergeable stores.
- Undefined: every accepted store allocates a new entry.

Decomposition:
- Package dm_pkg: ADDR_W, DATA_W, WORD_LSB=2, sb_entry_t struct {addr, data}, sb_state_e enum {NORMAL, FENCE, DONE}.
- One sub-module, sb_fwd_match: combinational youngest-first priority match over the entry array, valid mask and wr_ptr; outputs hit and data.

Test Plan:
- Store sequence:
  - Stimulus: reset, then store (0x08, 0xAA) with dm_hold=0.
  - Required: st_ready=1; the next cycle dm_MemWr=1, dm_addr=0x08, dm_data=0xAA; the cycle after, count=0.
- Full and blocked:
  - Stimulus: dm_hold=1, push 4 stores to 0x00, 0x04, 0x08, 0x0C.
  - Required: count=4, st_ready=0.
  - Stimulus: release hold.
  - Required: four consecutive strobes in order; st_ready returns to 1 after the first pop.
- Forward youngest:
  - Stimulus: dm_hold=1, stores (0x10,1) then (0x10,2); load 0x11.
  - Required: fwd_hit=1, fwd_data=2. A load to 0x14 gives fwd_hit=0.
- Fence:
  - Stimulus: 3 entries buffered, fence_req=1.
  - Required: st_ready=0 throughout, 3 strobes, then fence_done high for exactly one cycle, then NORMAL.
- Reset mid-drain:
  - Stimulus: 2 entries buffered, reset=1 for one cycle.
  - Required: count=0 and dm_MemWr=0 on the next cycle; fwd_hit=0.
- STORE_MERGE_EN:
  - Stimulus: dm_hold=1, stores (0x20,5), (0x24,6), (0x24,7).
  - Required: count=2; after release the strobes are 0x20/5 then 0x24/7.
